// File: rtl/mips_pkg.sv
// Shared datapath constants for the MIPS routing blocks.
package mips_pkg;
    localparam int   WORD_W   = 32;
    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;
endpackage

// File: rtl/word_fifo.sv
// Small word FIFO with occupancy counter. The head word is read straight from
// the storage array, so a word written at one edge is visible only after it.
// Full and empty are decided by the counter, never by pointer comparison.
module word_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              do_push;
    logic              do_pop;

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

    // Occupancy update: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers and counter; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Storage array; cleared on reset so the head word reads zero afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end
endmodule

// File: rtl/demux32bit_buf.sv
// Registered 1-to-2 word demultiplexer: each accepted word is buffered in the
// FIFO chosen by sel. in_ready looks only at sel and registered occupancy, so
// there is no combinational path from either consumer's ready to the producer.
module demux32bit_buf
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] Data_in,
    input  logic              sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] Data_out_0,
    output logic              out_valid_0,
    input  logic              out_ready_0,
    output logic [WORD_W-1:0] Data_out_1,
    output logic              out_valid_1,
    input  logic              out_ready_1,
    output logic [CNT_W-1:0]  count_0,
    output logic [CNT_W-1:0]  count_1
);
    logic full_0, full_1;
    logic empty_0, empty_1;
    logic push_0, push_1;

    // Destination decode and ready mux.
    always_comb begin
        in_ready = (sel == SEL_OUT0) ? ~full_0 : ~full_1;
        push_0   = in_valid & in_ready & (sel == SEL_OUT0);
        push_1   = in_valid & in_ready & (sel == SEL_OUT1);
    end

    assign out_valid_0 = ~empty_0;
    assign out_valid_1 = ~empty_1;

    word_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_0),
        .push_data (Data_in),
        .pop       (out_ready_0),
        .head_data (Data_out_0),
        .count     (count_0),
        .full      (full_0),
        .empty     (empty_0)
    );

    word_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_1),
        .push_data (Data_in),
        .pop       (out_ready_1),
        .head_data (Data_out_1),
        .count     (count_1),
        .full      (full_1),
        .empty     (empty_1)
    );
endmodule

// File: tb/tb_demux32bit_buf.sv
// Bench for demux32bit_buf: a table of fill/block/pop vectors, hand-written
// reset/route/stream sequences and random traffic, all checked against a
// per-destination queue model.
module tb_demux32bit_buf;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Data_in = '0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Data_out_0, Data_out_1;
    logic        out_valid_0, out_valid_1;
    logic        out_ready_0 = 1'b0;
    logic        out_ready_1 = 1'b0;
    logic [CNT_W-1:0] count_0, count_1;

    int total = 0;
    int bad = 0;

    int cnt0 = 0;
    int cnt1 = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    demux32bit_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Data_in     (Data_in),
        .sel         (sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Data_out_0  (Data_out_0),
        .out_valid_0 (out_valid_0),
        .out_ready_0 (out_ready_0),
        .Data_out_1  (Data_out_1),
        .out_valid_1 (out_valid_1),
        .out_ready_1 (out_ready_1),
        .count_0     (count_0),
        .count_1     (count_1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare against the model,
    // update the model for the coming rising edge.
    task automatic step(input bit rst, input bit v, input bit s, input logic [31:0] d,
                        input bit r0, input bit r1);
        bit exp_rdy, pop0, pop1, push;
        logic [31:0] w;
        @(negedge clk);
        rst_n = rst; in_valid = v; sel = s; Data_in = d;
        out_ready_0 = r0; out_ready_1 = r1;
        #1;
        exp_rdy = s ? (cnt1 != DEPTH) : (cnt0 != DEPTH);
        check("count_0", 32'(count_0), 32'(cnt0));
        check("count_1", 32'(count_1), 32'(cnt1));
        check("out_valid_0", 32'(out_valid_0), 32'(cnt0 != 0));
        check("out_valid_1", 32'(out_valid_1), 32'(cnt1 != 0));
        if (v) check("in_ready", 32'(in_ready), 32'(exp_rdy));
        pop0 = rst && r0 && (cnt0 != 0);
        pop1 = rst && r1 && (cnt1 != 0);
        push = rst && v && exp_rdy;
        if (pop0) begin w = q0.pop_front(); check("Data_out_0", Data_out_0, w); cnt0--; end
        if (pop1) begin w = q1.pop_front(); check("Data_out_1", Data_out_1, w); cnt1--; end
        $display("cyc rst_n=%0b v=%0b sel=%0b d=%h r0=%0b r1=%0b push=%0b pop0=%0b pop1=%0b",
                 rst, v, s, d, r0, r1, push, pop0, pop1);
        if (push && !s) begin q0.push_back(d); cnt0++; end
        if (push && s)  begin q1.push_back(d); cnt1++; end
        if (!rst) begin cnt0 = 0; cnt1 = 0; q0.delete(); q1.delete(); end
    endtask

    typedef struct {
        bit          v;
        bit          s;
        logic [31:0] d;
        bit          r0;
        bit          r1;
        bit          exp_rdy;
        int          exp_c0;
        int          exp_c1;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // Fill, block, cross-destination push, full-with-pop, drain.
        tbl[0] = '{1'b1, 1'b0, 32'hA0, 1'b0, 1'b0, 1'b1, 1, 0};
        tbl[1] = '{1'b1, 1'b0, 32'hA1, 1'b0, 1'b0, 1'b1, 2, 0};
        tbl[2] = '{1'b1, 1'b0, 32'hA2, 1'b0, 1'b0, 1'b0, 2, 0};
        tbl[3] = '{1'b1, 1'b1, 32'hB0, 1'b0, 1'b0, 1'b1, 2, 1};
        tbl[4] = '{1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, 1'b0, 1, 1};
        tbl[5] = '{1'b1, 1'b0, 32'hA2, 1'b0, 1'b0, 1'b1, 2, 1};
        tbl[6] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1, 0};
        tbl[7] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 0, 0};

        // Reset held two cycles with a live handshake that must be ignored.
        step(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("reset_Data_out_0", Data_out_0, 32'h0);
        check("reset_Data_out_1", Data_out_1, 32'h0);

        // Single route to output 1, no bypass, pop one cycle later.
        step(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Table-driven fill/block sequence.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1);
            if (tbl[i].v) check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            @(posedge clk); #1;
            check($sformatf("tbl%0d_count_0", i), 32'(count_0), 32'(tbl[i].exp_c0));
            check($sformatf("tbl%0d_count_1", i), 32'(count_1), 32'(tbl[i].exp_c1));
        end

        // Streaming across pointer wrap with the consumer always ready.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
            @(posedge clk); #1;
            check("stream_count_0_le1", 32'(count_0 <= 1), 32'd1);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Mid-operation reset flushes both buffers.
        step(1'b1, 1'b1, 1'b0, 32'h55, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h66, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h77, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'hC0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Random traffic against the queue model.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Drain and confirm nothing was lost.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("final_q0_empty", 32'(q0.size()), 32'd0);
        check("final_q1_empty", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux32bit_buf.md
Name: demux32bit_buf

Overview:
- Registered 1-to-2 demultiplexer for 32-bit data words: the routing counterpart of the 32-bit 2:1 select mux.
- One valid/ready input stream carries a word plus a 1-bit destination select.
- Each accepted word is buffered in a per-destination FIFO and presented on output 0 or output 1 under independent valid/ready handshakes.
- Used in the MIPS datapath to steer a result word (e.g. memory read data) to one of two consumers without a combinational ready path between them.

Parameters:
- DEPTH, 2, entries per output buffer; power of two, >= 2.
- CNT_W, 2, occupancy counter width; equals log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- Data_in  input  32  word to route.
- sel  input  1  destination: 0 -> output 0, 1 -> output 1.
- in_valid  input  1  Data_in/sel valid.
- in_ready  output  1  block accepts the word this cycle.
- Data_out_0  output  32  head word of buffer 0.
- out_valid_0  output  1  buffer 0 non-empty.
- out_ready_0  input  1  consumer 0 takes the head word.
- Data_out_1  output  32  head word of buffer 1.
- out_valid_1  output  1  buffer 1 non-empty.
- out_ready_1  input  1  consumer 1 takes the head word.
- count_0  output  CNT_W  occupancy of buffer 0.
- count_1  output  CNT_W  occupancy of buffer 1.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (rst_n sampled on clk rising edge).
- Reset values: out_valid_0/1 = 0, count_0/1 = 0, Data_out_0/1 = 32'h0, all read/write pointers = 0. in_ready is combinational and reads 1 once counts are 0.
- Reset asserted mid-operation flushes both buffers. Any handshake in a reset cycle is ignored.
- in_ready = (sel==0) ? (count_0 != DEPTH) : (count_1 != DEPTH).
  - Depends only on sel and registered occupancy, never on out_ready_x.
  - in_ready is meaningful only when in_valid=1; it is stable for a stable sel.
- Push: when in_valid & in_ready, Data_in is written at the wr_ptr of buffer[sel], and wr_ptr/count of that buffer update at the clock edge.
- The unselected buffer is never written.
- Latency: a word pushed at edge N is visible on Data_out_x with out_valid_x=1 after edge N (earliest pop at edge N+1). There is no bypass, even when the buffer is empty.
- Pop on output x: when out_valid_x & out_ready_x, rd_ptr_x increments at the edge and count_x decrements.
- Data_out_x always shows mem_x[rd_ptr_x]. When empty it holds the last value and is don't-care.
- Simultaneous push and pop on the same buffer:
  - count unchanged, both pointers advance.
  - Legal when non-empty and not full.
  - When full, the push is blocked (in_ready=0) but the pop proceeds, so full-throughput steady state occurs at count < DEPTH.
- Push to one buffer and pop from the other in the same cycle: the two are independent.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided by count, never by pointer comparison.
- Ordering: FIFO order is preserved per destination. There is no ordering relation across destinations.
- out_valid_x = (count_x != 0), registered-equivalent (derived from the count register).
- in_valid=0: no state change on the input side, regardless of sel.
- Verification checks:
  - count_x never exceeds DEPTH and never underflows.
  - A pop with out_valid_x=0 has no effect.

Decomposition:
- Shared package mips_pkg: WORD_W = 32, and the constants SEL_OUT0 = 1'b0, SEL_OUT1 = 1'b1.
- Natural sub-module: word_fifo (parameters DEPTH, CNT_W; ports push, push_data, pop, head_data, count, full, empty; clk/rst_n).
  - Instantiated twice.
  - Top level holds only sel decode, in_ready mux and wiring.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, sel=0, Data_in=32'hDEAD_BEEF -> after release count_0=count_1=0, out_valid_0/1=0, nothing captured.
- Single route: push 32'h1234_5678 with sel=1 at edge N -> out_valid_1=1 and Data_out_1=32'h1234_5678 after N; out_valid_0 stays 0; pop at N+1 -> count_1=0.
- Fill and block: out_ready_0=0; push 32'hA0, 32'hA1, then 32'hA2 on sel=0 -> third cycle in_ready=0, count_0=2. A concurrent sel=1 push of 32'hB0 is accepted (count_1=1).
- Full with pop: buffer 0 full, out_ready_0=1, in_valid=1, sel=0 -> pop of 32'hA0 occurs, push blocked that cycle; next cycle in_ready=1 and 32'hA2 is accepted; drain order A1, A2.
- Streaming and wrap: out_ready_0=1 continuously, push 10 words 32'h0..32'h9 on sel=0 back-to-back -> all accepted in order across pointer wrap; count_0 stays <=1 after the first word.
- Mid-operation reset: both buffers non-empty, pulse rst_n=0 for 1 cycle -> both counts 0 and out_valid_0/1=0 the next cycle; subsequent push of 32'hC0 to sel=0 appears first on output 0.
